// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator:
// op codes, FSM states and the default datapath width.
package calc_pkg;

   localparam int DEF_WIDTH = 6;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MUL  = 3'd2,
      OP_DIV  = 3'd3,
      OP_MOD  = 3'd4,
      OP_POW  = 3'd5,
      OP_FACT = 3'd6,
      OP_BAD  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Any raw code above factorial collapses to OP_BAD.
   function automatic op_e decode_op(input logic [15:0] code);
      if (code > 16'd6) return OP_BAD;
      return op_e'(code[2:0]);
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: loads on start, then produces one
// quotient bit per cycle for WIDTH cycles.
module seq_divider
   import calc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             last,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             take;

   // One restoring step; outputs show the result of the step
   // taken on the coming edge, so they are final while last=1.
   always_comb begin
      rem_sh    = {rem_q, quo_q[WIDTH-1]};
      take      = rem_sh >= {1'b0, dvs_q};
      diff      = rem_sh[WIDTH-1:0] - dvs_q;
      remainder = take ? diff : rem_sh[WIDTH-1:0];
      quotient  = {quo_q[WIDTH-2:0], take};
   end

   assign last = (cnt_q == CW'(1));
   assign div0 = (dvs_q == '0);

   // Load operands on start, then shift one bit per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= CW'(WIDTH);
      end else if (cnt_q != '0) begin
         rem_q <= remainder;
         quo_q <= quotient;
         cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/seq_calculator.sv
// Multi-cycle calculator: add/sub/mul in one cycle, div/mod
// via seq_divider, pow and factorial by iterated multiply.
module seq_calculator
   import calc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic [OPW-1:0]   operator,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             error
);

   localparam int PW = 2 * WIDTH;

   state_e           state;
   op_e              op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] idx_q;
   logic             ovf_q;
   logic             accept;

   logic [WIDTH-1:0] mul_x;
   logic [WIDTH-1:0] mul_y;
   logic [PW-1:0]    prod;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] limit;
   logic             ovf_step;
   logic             fin;
   logic [WIDTH-1:0] res;
   logic             err;

   logic             dv_last;
   logic [WIDTH-1:0] dv_quo;
   logic [WIDTH-1:0] dv_rem;
   logic             dv_zero;

   assign in_ready = (state == S_IDLE);
   assign accept   = in_valid && in_ready;

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (accept),
      .dividend  (data_a),
      .divisor   (data_b),
      .last      (dv_last),
      .quotient  (dv_quo),
      .remainder (dv_rem),
      .div0      (dv_zero)
   );

   // Shared multiplier: a*b for mul, acc*a for pow, acc*i for fact.
   always_comb begin
      mul_x = (op_q == OP_MUL) ? a_q : acc_q;
      mul_y = (op_q == OP_MUL) ? b_q :
              (op_q == OP_POW) ? a_q : idx_q;
      prod  = PW'(mul_x) * PW'(mul_y);
   end

   // Result and completion for the current CALC cycle.
   always_comb begin
      fin      = 1'b0;
      res      = '0;
      err      = 1'b0;
      sum      = {1'b0, a_q} + {1'b0, b_q};
      limit    = (op_q == OP_POW) ? b_q : a_q;
      ovf_step = ovf_q | (|prod[PW-1:WIDTH]);
      unique case (op_q)
         OP_ADD: begin
            fin = 1'b1;
            res = sum[WIDTH-1:0];
            err = sum[WIDTH];
         end
         OP_SUB: begin
            fin = 1'b1;
            res = a_q - b_q;
            err = a_q < b_q;
         end
         OP_MUL: begin
            fin = 1'b1;
            res = prod[WIDTH-1:0];
            err = |prod[PW-1:WIDTH];
         end
         OP_DIV, OP_MOD: begin
            fin = dv_last;
            res = dv_zero ? '1 :
                  (op_q == OP_DIV) ? dv_quo : dv_rem;
            err = dv_zero;
         end
         OP_POW, OP_FACT: begin
            if (limit == '0) begin
               fin = 1'b1;
               res = WIDTH'(1);
            end else begin
               fin = (idx_q == limit);
               res = prod[WIDTH-1:0];
               err = ovf_step;
            end
         end
         default: begin
            fin = 1'b1;
            err = 1'b1;
         end
      endcase
   end

   // Control FSM with registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= OP_ADD;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
         data_out  <= '0;
         error     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  a_q   <= data_a;
                  b_q   <= data_b;
                  op_q  <= decode_op(16'(operator));
                  acc_q <= WIDTH'(1);
                  idx_q <= WIDTH'(1);
                  ovf_q <= 1'b0;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               acc_q <= prod[WIDTH-1:0];
               idx_q <= idx_q + WIDTH'(1);
               ovf_q <= ovf_step;
               if (fin) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  data_out  <= res;
                  error     <= err;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  data_out  <= '0;
                  error     <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed bench for seq_calculator at WIDTH=6 with
// hand-computed results, latencies and handshake checks.
module tb_seq_calculator;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] data_a;
   logic [W-1:0] data_b;
   logic [3:0]   operator;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] data_out;
   logic         error;

   int errors = 0;
   int checks = 0;

   seq_calculator #(.WIDTH(W), .OPW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_a    (data_a),
      .data_b    (data_b),
      .operator  (operator),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one request and wait (bounded) for its result.
   task automatic run_op(input string tag, input int a, input int b,
                         input int op, input int exp_res,
                         input int exp_err, input int exp_lat);
      int cnt;
      in_valid  = 1'b1;
      data_a    = W'(a);
      data_b    = W'(b);
      operator  = 4'(op);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_a   = W'(a + 11);
      data_b   = W'(b + 5);
      operator = 4'(op + 1);
      cnt = 0;
      while (!out_valid && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({tag, " latency"}, cnt, exp_lat);
      chk({tag, " data"}, int'(data_out), exp_res);
      chk({tag, " error"}, int'(error), exp_err);
      @(posedge clk); #1;
      chk({tag, " drained"}, int'(out_valid), 0);
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      data_a    = '0;
      data_b    = '0;
      operator  = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst in_ready", int'(in_ready), 1);
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst data_out", int'(data_out), 0);
      chk("rst error", int'(error), 0);
      @(posedge clk); #1;

      run_op("add 40+30", 40, 30, 0, 6, 1, 1);
      run_op("add 10+20", 10, 20, 0, 30, 0, 1);
      run_op("sub 20-5", 20, 5, 1, 15, 0, 1);
      run_op("sub 5-20", 5, 20, 1, 49, 1, 1);
      run_op("mul 7*9", 7, 9, 2, 63, 0, 1);
      run_op("mul 8*8", 8, 8, 2, 0, 1, 1);
      run_op("div 45/7", 45, 7, 3, 6, 0, 6);
      run_op("mod 45/7", 45, 7, 4, 3, 0, 6);
      run_op("div 9/0", 9, 0, 3, 63, 1, 6);
      run_op("mod 9/0", 9, 0, 4, 63, 1, 6);
      run_op("div 63/1", 63, 1, 3, 63, 0, 6);
      run_op("pow 3^3", 3, 3, 5, 27, 0, 3);
      run_op("pow 2^6", 2, 6, 5, 0, 1, 6);
      run_op("pow 5^0", 5, 0, 5, 1, 0, 1);
      run_op("fact 4", 4, 0, 6, 24, 0, 4);
      run_op("fact 5", 5, 0, 6, 56, 1, 5);
      run_op("fact 0", 0, 0, 6, 1, 0, 1);
      run_op("bad op 9", 12, 3, 9, 0, 1, 1);

      // Back-pressure: result must hold while out_ready is low.
      in_valid  = 1'b1;
      data_a    = W'(5);
      data_b    = W'(6);
      operator  = 4'd2;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold valid", int'(out_valid), 1);
      in_valid = 1'b1;
      data_a   = W'(1);
      data_b   = W'(1);
      operator = 4'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold data", int'(data_out), 30);
         chk("hold in_ready", int'(in_ready), 0);
         chk("hold out_valid", int'(out_valid), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release out_valid", int'(out_valid), 0);
      chk("release in_ready", int'(in_ready), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("ignored request", int'(out_valid), 0);

      // Reset in the middle of a divide aborts it.
      in_valid = 1'b1;
      data_a   = W'(45);
      data_b   = W'(7);
      operator = 4'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort out_valid", int'(out_valid), 0);
      chk("abort data_out", int'(data_out), 0);
      chk("abort error", int'(error), 0);
      @(posedge clk); #1;
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("abort no result", seen, 0);
      chk("abort in_ready", int'(in_ready), 1);
      run_op("div 50/8", 50, 8, 3, 6, 0, 6);
      run_op("mod 50/8", 50, 8, 4, 2, 0, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_calculator.md
SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 Parameter WIDTH, default 6: operand and result width in bits; legal range 4..16.
REQ-002 Parameter OPW, default 4: operator code width in bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  request present on data_a/data_b/operator.
REQ-006 in_ready  out  1  block can accept a request (high only in IDLE).
REQ-007 data_a  in  WIDTH  first operand, unsigned.
REQ-008 data_b  in  WIDTH  second operand, unsigned.
REQ-009 operator  in  OPW  op code: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 pow, 6 factorial; 7..2^OPW-1 invalid.
REQ-010 out_valid  out  1  data_out/error hold a completed result.
REQ-011 out_ready  in  1  consumer takes the result.
REQ-012 data_out  out  WIDTH  result, low WIDTH bits.
REQ-013 error  out  1  result overflowed, divide-by-zero, or invalid op.

Function
REQ-014 FSM states IDLE, CALC, DONE; the block SHALL accept a request only on an edge where in_valid && in_ready.
REQ-015 On accept, the block SHALL latch data_a, data_b, operator and go to CALC; input changes after accept SHALL be ignored.
REQ-016 Latency L, measured from the accept edge to the edge that enters DONE: 1 for add/sub/mul/invalid, WIDTH for div/mod, max(data_b,1) for pow, max(data_a,1) for factorial.
REQ-017 In DONE, out_valid SHALL be 1 and data_out/error SHALL remain stable until an edge with out_ready=1; on that edge the FSM SHALL go to IDLE.
REQ-018 in_ready SHALL be 0 in CALC and DONE; there SHALL be no same-cycle result-drain and new-accept.
REQ-019 add: result = (a+b) mod 2^WIDTH; error = carry out.
REQ-020 sub: result = (a-b) mod 2^WIDTH; error = (a<b).
REQ-021 mul: a 2*WIDTH-bit product; result = low WIDTH bits; error = any upper bit set.
REQ-022 div/mod: restoring divider, one quotient bit per cycle; div result = quotient, mod result = remainder.
REQ-023 div/mod with b=0: result = all ones, error = 1, latency unchanged.
REQ-024 pow: acc starts at 1; each CALC cycle acc = low(acc*a); error sticky if any product exceeds WIDTH bits; b=0 gives 1, error 0 (0^0 = 1).
REQ-025 factorial: acc starts at 1; cycle i (1..a) acc = low(acc*i); overflow sticky as in pow; a=0 gives 1.
REQ-026 invalid op: result 0, error 1.
REQ-027 data_out and error SHALL be 0 whenever out_valid=0.

Reset
REQ-028 rst=1 SHALL force IDLE, in_ready=1 after release, out_valid=0, data_out=0, error=0, all accumulators/counters 0.
REQ-029 rst asserted in CALC or DONE SHALL abort the operation; no result SHALL be emitted for it.

Structure
REQ-030 Package calc_pkg SHALL hold the op-code constants, the FSM state enum and the default WIDTH.
REQ-031 The divider SHALL be the sub-module seq_divider (start, WIDTH-cycle restoring, quotient/remainder/div0 outputs); everything else lives in seq_calculator.

Verification
REQ-032 WIDTH=6, add 40+30, out_ready=1 -> out_valid 1 edge after accept, data_out=6, error=1.
REQ-033 div 45/7 -> data_out=6 after exactly 6 cycles; mod 45/7 -> 3; div 9/0 -> 63, error=1.
REQ-034 pow 3^3 -> 27, error 0, L=3; pow 2^6 -> 0, error 1; pow 5^0 -> 1, L=1.
REQ-035 factorial 4 -> 24, error 0; factorial 5 -> 120 mod 64 = 56, error 1; factorial 0 -> 1.
REQ-036 hold out_ready=0 for 5 cycles in DONE -> data_out stable, in_ready 0, new in_valid ignored; then out_ready=1 -> IDLE next edge.
REQ-037 assert rst mid-div (cycle 3) -> outputs 0 immediately, no out_valid; next request after release completes correctly.
